// File: rtl/overlay_pkg.sv
// Shared types for the overlay layer: fade state encoding, level range
// and the 3x4-bit colour bundle used through the pixel pipeline.
package overlay_pkg;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } ovl_state_t;

    localparam logic [3:0] LEVEL_MAX = 4'd15;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

endpackage

// File: rtl/overlay_if.sv
// Pixel-stream bundle between the raster/ROM/palette side and the overlay
// controller, plus the controller's status and debug state.
interface overlay_if;
    import overlay_pkg::*;

    // No valid/ready: every vga_clk carries one pixel; DrawX/DrawY/blank/bg
    // describe the current pixel, rom_q/pal_* answer rom_address one cycle on.
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        show_req;
    logic        hide_req;
    logic [15:0] rom_address;
    logic [3:0]  rom_q;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [3:0]  red, green, blue;
    logic        overlay_visible;
    logic        busy;
    ovl_state_t  dbg_state;

    modport master (
        output DrawX, DrawY, blank, show_req, hide_req, rom_q,
               pal_red, pal_green, pal_blue, bg_red, bg_green, bg_blue,
        input  rom_address, red, green, blue, overlay_visible, busy, dbg_state
    );

    modport slave (
        input  DrawX, DrawY, blank, show_req, hide_req, rom_q,
               pal_red, pal_green, pal_blue, bg_red, bg_green, bg_blue,
        output rom_address, red, green, blue, overlay_visible, busy, dbg_state
    );

endinterface

// File: rtl/overlay_blend.sv
// One colour channel of the final stage: mixes palette over background by
// level/16 and registers the result.
module overlay_blend
    import overlay_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [3:0] bg_i,
    input  logic [3:0] pal_i,
    input  logic [3:0] level_i,
    input  logic       use_ovl_i,
    input  logic       blank_i,
    output logic [3:0] out_o
);

    logic [3:0] mag;
    logic [7:0] prod;
    logic [4:0] sum;
    logic [3:0] mix;
    logic [3:0] out_d, out_q;

    // The step is taken on |pal-bg| so it rounds toward zero in both
    // directions; the clamp guards the add/subtract against wrap.
    always_comb begin
        mag  = (pal_i >= bg_i) ? (pal_i - bg_i) : (bg_i - pal_i);
        prod = {4'd0, mag} * {4'd0, level_i};
        if (pal_i >= bg_i) begin
            sum = {1'b0, bg_i} + {1'b0, prod[7:4]};
            mix = sum[4] ? 4'hF : sum[3:0];
        end else begin
            sum = {1'b0, bg_i} - {1'b0, prod[7:4]};
            mix = sum[4] ? 4'h0 : sum[3:0];
        end

        out_d = mix;
        if (!blank_i)                   out_d = 4'h0;
        else if (!use_ovl_i)            out_d = bg_i;
        else if (level_i == LEVEL_MAX)  out_d = pal_i;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) out_q <= 4'h0;
        else       out_q <= out_d;
    end

    assign out_o = out_q;

endmodule

// File: rtl/overlay_controller.sv
// Full-screen overlay layer: raster-order ROM addressing, frame-stepped
// show/hide fade FSM and a 3-stage pipeline to the registered RGB output.
module overlay_controller
    import overlay_pkg::*;
#(
    parameter int         IMG_W       = 400,
    parameter int         IMG_H       = 150,
    parameter int         ORIGIN_X    = 120,
    parameter int         ORIGIN_Y    = 165,
    parameter int         FADE_FRAMES = 2,
    parameter logic [3:0] TRANSP_IDX  = 4'd0
) (
    input  logic      vga_clk,
    input  logic      reset,
    overlay_if.slave  bus
);

    localparam logic [15:0] ADDR_MAX = 16'(IMG_W * IMG_H - 1);
    localparam logic [9:0]  X_LO     = 10'(ORIGIN_X);
    localparam logic [9:0]  X_HI     = 10'(ORIGIN_X + IMG_W - 1);
    localparam logic [9:0]  Y_LO     = 10'(ORIGIN_Y);
    localparam logic [9:0]  Y_HI     = 10'(ORIGIN_Y + IMG_H - 1);
    localparam int          CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

    logic        frame_start, in_win, use_ovl;
    logic        armed_q;
    logic [15:0] addr_cnt_q, rom_addr_q;
    logic        hit1_q, blank1_q, hit2_q, blank2_q;
    rgb4_t       bg1_q, bg2_q;

    ovl_state_t       state_q, state_d;
    logic [3:0]       level_q, level_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             pend_show_q, pend_show_d, pend_hide_q, pend_hide_d;
    logic             visible_q, busy_q;

    assign frame_start = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
    // armed_q keeps the addresser idle after a mid-frame reset.
    assign in_win = armed_q && bus.blank &&
                    (bus.DrawX >= X_LO) && (bus.DrawX <= X_HI) &&
                    (bus.DrawY >= Y_LO) && (bus.DrawY <= Y_HI);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            armed_q    <= 1'b0;
            addr_cnt_q <= 16'd0;
            rom_addr_q <= 16'd0;
            hit1_q     <= 1'b0;
            blank1_q   <= 1'b0;
            bg1_q      <= '0;
            hit2_q     <= 1'b0;
            blank2_q   <= 1'b0;
            bg2_q      <= '0;
        end else begin
            if (frame_start) begin
                armed_q    <= 1'b1;
                addr_cnt_q <= 16'd0;
            end else if (in_win) begin
                rom_addr_q <= addr_cnt_q;
                if (addr_cnt_q != ADDR_MAX) addr_cnt_q <= addr_cnt_q + 16'd1;
            end
            hit1_q   <= in_win;
            blank1_q <= bus.blank;
            bg1_q    <= {bus.bg_red, bus.bg_green, bus.bg_blue};
            hit2_q   <= hit1_q;
            blank2_q <= blank1_q;
            bg2_q    <= bg1_q;
        end
    end

    // A request landing on the frame_start cycle waits for the next frame.
    always_comb begin
        pend_show_d = frame_start ? 1'b0 : pend_show_q;
        pend_hide_d = frame_start ? 1'b0 : pend_hide_q;
        if (bus.hide_req) begin
            pend_hide_d = 1'b1;
            pend_show_d = 1'b0;
        end else if (bus.show_req) begin
            pend_show_d = 1'b1;
            pend_hide_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        fcnt_d  = fcnt_q;
        if (frame_start) begin
            case (state_q)
                HIDDEN: if (pend_show_q) begin
                    state_d = FADE_IN;
                    fcnt_d  = '0;
                end
                FADE_IN: if (pend_hide_q) begin
                    state_d = (level_q == 4'd0) ? HIDDEN : FADE_OUT;
                    fcnt_d  = '0;
                end else if (fcnt_q == CNT_LAST) begin
                    fcnt_d  = '0;
                    level_d = level_q + 4'd1;
                    if (level_q == LEVEL_MAX - 4'd1) state_d = SHOWN;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
                SHOWN: if (pend_hide_q) begin
                    state_d = FADE_OUT;
                    fcnt_d  = '0;
                end
                FADE_OUT: if (pend_show_q) begin
                    state_d = (level_q == LEVEL_MAX) ? SHOWN : FADE_IN;
                    fcnt_d  = '0;
                end else if (fcnt_q == CNT_LAST) begin
                    fcnt_d  = '0;
                    level_d = level_q - 4'd1;
                    if (level_q == 4'd1) state_d = HIDDEN;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
                default: state_d = HIDDEN;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q     <= HIDDEN;
            level_q     <= 4'd0;
            fcnt_q      <= '0;
            pend_show_q <= 1'b0;
            pend_hide_q <= 1'b0;
            visible_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            fcnt_q      <= fcnt_d;
            pend_show_q <= pend_show_d;
            pend_hide_q <= pend_hide_d;
            visible_q   <= (state_d != HIDDEN);
            busy_q      <= (state_d == FADE_IN) || (state_d == FADE_OUT);
        end
    end

    assign use_ovl = hit2_q && (level_q != 4'd0) && (bus.rom_q != TRANSP_IDX);

    overlay_blend u_blend_r (
        .vga_clk(vga_clk), .reset(reset), .bg_i(bg2_q.r), .pal_i(bus.pal_red),
        .level_i(level_q), .use_ovl_i(use_ovl), .blank_i(blank2_q), .out_o(bus.red)
    );
    overlay_blend u_blend_g (
        .vga_clk(vga_clk), .reset(reset), .bg_i(bg2_q.g), .pal_i(bus.pal_green),
        .level_i(level_q), .use_ovl_i(use_ovl), .blank_i(blank2_q), .out_o(bus.green)
    );
    overlay_blend u_blend_b (
        .vga_clk(vga_clk), .reset(reset), .bg_i(bg2_q.b), .pal_i(bus.pal_blue),
        .level_i(level_q), .use_ovl_i(use_ovl), .blank_i(blank2_q), .out_o(bus.blue)
    );

    assign bus.rom_address     = rom_addr_q;
    assign bus.overlay_visible = visible_q;
    assign bus.busy            = busy_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_overlay_controller.sv
// Directed bench for overlay_controller: one pixel per clock, RGB expected
// three pixels later, ROM/palette answer modelled with matching latency.
module tb_overlay_controller;
  import overlay_pkg::*;

  logic clk;
  logic reset;
  overlay_if bus();

  overlay_controller dut (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word {idx, pal r, pal g, pal b}: address answered next cycle, so the
  // value for a pixel lines up two cycles after the pixel itself.
  logic [15:0] rom_v, rom_d1, rom_d2;
  always @(posedge clk) begin
    rom_d1 <= rom_v;
    rom_d2 <= rom_d1;
  end
  assign bus.rom_q     = rom_d2[15:12];
  assign bus.pal_red   = rom_d2[11:8];
  assign bus.pal_green = rom_d2[7:4];
  assign bus.pal_blue  = rom_d2[3:0];

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];
  logic        prev_achk = 1'b0;
  logic [15:0] prev_aexp = 16'd0;
  logic        pend_s = 1'b0;
  logic        pend_h = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one pixel per call; checks RGB of the pixel three calls back
  // and rom_address of the pixel one call back.
  task automatic drive_px(input string tag, input logic [9:0] x, input logic [9:0] y,
                          input logic b, input logic [11:0] bg, input logic [15:0] rom,
                          input logic chk, input logic [11:0] exp,
                          input logic achk, input logic [15:0] aexp);
    logic [12:0] e;
    string       t;
    @(posedge clk);
    #1;
    if (prev_achk) check("rom_address", bus.rom_address, prev_aexp);
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e[12]) check(t, {4'd0, bus.red, bus.green, bus.blue}, {4'd0, e[11:0]});
    end
    bus.DrawX    = x;
    bus.DrawY    = y;
    bus.blank    = b;
    bus.bg_red   = bg[11:8];
    bus.bg_green = bg[7:4];
    bus.bg_blue  = bg[3:0];
    rom_v        = rom;
    bus.show_req = pend_s;
    bus.hide_req = pend_h;
    pend_s       = 1'b0;
    pend_h       = 1'b0;
    exp_q.push_back({chk, exp});
    tag_q.push_back(tag);
    prev_achk = achk;
    prev_aexp = aexp;
  endtask

  task automatic px(input string tag, input logic [9:0] x, input logic [9:0] y, input logic b,
                    input logic [11:0] bg, input logic [15:0] rom, input logic [11:0] exp);
    drive_px(tag, x, y, b, bg, rom, 1'b1, exp, 1'b0, 16'd0);
  endtask

  task automatic idle();
    px("idle_rgb", 10'd700, 10'd500, 1'b0, 12'hABC, 16'h3FFF, 12'h000);
  endtask

  task automatic frame();
    px("frame_rgb", 10'd0, 10'd0, 1'b0, 12'h321, 16'h3FFF, 12'h000);
    idle();
  endtask

  task automatic request(input logic s, input logic h);
    pend_s = s;
    pend_h = h;
    idle();
  endtask

  task automatic chk_state(input string tag, input logic vis, input logic bsy);
    check({tag, "_visible"}, {15'd0, bus.overlay_visible}, {15'd0, vis});
    check({tag, "_busy"}, {15'd0, bus.busy}, {15'd0, bsy});
  endtask

  initial begin
    reset        = 1'b1;
    bus.DrawX    = 10'd200;
    bus.DrawY    = 10'd200;
    bus.blank    = 1'b1;
    bus.bg_red   = 4'h5;
    bus.bg_green = 4'hA;
    bus.bg_blue  = 4'h3;
    bus.show_req = 1'b0;
    bus.hide_req = 1'b0;
    rom_v        = 16'h3F00;

    // reset held 3 cycles mid-frame
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_rgb", {4'd0, bus.red, bus.green, bus.blue}, 16'h0000);
      check("reset_rom_address", bus.rom_address, 16'd0);
      chk_state("reset", 1'b0, 1'b0);
    end
    reset = 1'b0;

    // before any frame_start: background passthrough, addresser idle
    drive_px("pre_bg0", 10'd200, 10'd200, 1'b1, 12'h123, 16'h3F00, 1'b1, 12'h123, 1'b1, 16'd0);
    drive_px("pre_bg1", 10'd201, 10'd200, 1'b1, 12'h456, 16'h3F00, 1'b1, 12'h456, 1'b1, 16'd0);
    drive_px("pre_bg2", 10'd202, 10'd200, 1'b1, 12'h789, 16'h3F00, 1'b1, 12'h789, 1'b1, 16'd0);
    frame();
    px("hidden_bg", 10'd300, 10'd200, 1'b1, 12'h9E1, 16'h3F00, 12'h9E1);
    chk_state("hidden", 1'b0, 1'b0);

    // fade in: level steps every second frame_start
    request(1'b1, 1'b0);
    for (int n = 0; n <= 30; n++) begin
      frame();
      if (n == 0) chk_state("fadein_start", 1'b1, 1'b1);
      if (n == 16) begin
        px("lvl8_mix", 10'd200, 10'd200, 1'b1, 12'h0F8, 16'h3F08, 12'h788);
        px("lvl8_transp", 10'd201, 10'd200, 1'b1, 12'h0F8, 16'h0F08, 12'h0F8);
        px("lvl8_outside", 10'd50, 10'd200, 1'b1, 12'h0F8, 16'h3F08, 12'h0F8);
        px("lvl8_mix2", 10'd202, 10'd200, 1'b1, 12'h42A, 16'h3CA2, 12'h866);
      end
      if (n == 29) chk_state("fadein_f29", 1'b1, 1'b1);
      if (n == 30) chk_state("shown", 1'b1, 1'b0);
    end

    // raster addressing over one full image
    frame();
    for (int y = 165; y <= 314; y++) begin
      for (int x = 120; x <= 519; x++) begin
        logic        ac;
        logic [15:0] ae;
        ac = 1'b0;
        ae = 16'd0;
        if (y == 165 && x == 120) begin ac = 1'b1; ae = 16'd0;     end
        if (y == 165 && x == 519) begin ac = 1'b1; ae = 16'd399;   end
        if (y == 166 && x == 120) begin ac = 1'b1; ae = 16'd400;   end
        if (y == 200 && x == 130) begin ac = 1'b1; ae = 16'd14010; end
        if (y == 314 && x == 519) begin ac = 1'b1; ae = 16'd59999; end
        drive_px("addr_scan", 10'(x), 10'(y), 1'b1, 12'h000, 16'h0000, 1'b0, 12'h000, ac, ae);
      end
    end
    drive_px("addr_sat", 10'd200, 10'd300, 1'b1, 12'h000, 16'h0000, 1'b0, 12'h000, 1'b1, 16'd59999);
    drive_px("addr_hold", 10'd700, 10'd300, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h000, 1'b1, 16'd59999);

    // shown colours
    px("shown_transp", 10'd200, 10'd200, 1'b1, 12'h00F, 16'h0F00, 12'h00F);
    px("shown_pal", 10'd201, 10'd200, 1'b1, 12'h00F, 16'h3F00, 12'hF00);
    px("shown_blank", 10'd202, 10'd200, 1'b0, 12'h00F, 16'h3F00, 12'h000);
    px("shown_outside", 10'd50, 10'd200, 1'b1, 12'h00F, 16'h3F00, 12'h00F);
    px("shown_pal5", 10'd203, 10'd200, 1'b1, 12'h00F, 16'h55A5, 12'h5A5);
    request(1'b1, 1'b0);
    frame();
    chk_state("redundant_show", 1'b1, 1'b0);

    // fade out to hidden
    request(1'b0, 1'b1);
    for (int n = 0; n <= 30; n++) begin
      frame();
      if (n == 0) chk_state("fadeout_start", 1'b1, 1'b1);
      if (n == 16) px("lvl7_mix", 10'd200, 10'd200, 1'b1, 12'h0F8, 16'h3F08, 12'h698);
      if (n == 29) chk_state("fadeout_f29", 1'b1, 1'b1);
      if (n == 30) chk_state("hidden_again", 1'b0, 1'b0);
    end

    // same-cycle show and hide in HIDDEN: hide wins
    request(1'b1, 1'b1);
    frame();
    chk_state("both_req", 1'b0, 1'b0);
    frame();
    chk_state("both_req_f2", 1'b0, 1'b0);

    // hide at level 10 during fade in
    request(1'b1, 1'b0);
    for (int n = 0; n <= 20; n++) frame();
    px("lvl10_in", 10'd200, 10'd200, 1'b1, 12'h0F8, 16'h3F08, 12'h968);
    request(1'b0, 1'b1);
    frame();
    chk_state("reverse", 1'b1, 1'b1);
    px("lvl10_out", 10'd200, 10'd200, 1'b1, 12'h0F8, 16'h3F08, 12'h968);
    frame();
    frame();
    px("lvl9_out", 10'd200, 10'd200, 1'b1, 12'h0F8, 16'h3F08, 12'h878);
    chk_state("reverse_f3", 1'b1, 1'b1);

    // drain the expected queue
    idle();
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
